uart_rx_core: RTL and testbench

Serial-to-parallel UART receive core: the counterpart of the transmit-side parallel-to-serial shifter. It detects a start bit on an idle-high line, samples DATA_BITS data bits LSB-first at mid-bit, checks the stop bit and presents the byte in a holding register with ready, overrun and framing flags. It sits between the chip's serial input pad and the pixel/command unpacking logic.

---
 rtl/uart_rx_core_if.sv | 36 +++
 rtl/uart_rx_core.sv | 158 +++++++++++++++
 tb/tb_uart_rx_core.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core_if
// Description : Serial line, read acknowledge and received-byte bundle for
//               the UART receive core.
// Revision    : 1.0
// ============================================================================
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic                 serial_in;
    logic                 data_read;
    logic [DATA_BITS-1:0] rx_data;
    logic                 data_ready;
    logic                 overrun_error;
    logic                 framing_error;

    modport master (
        input  serial_in,
        input  data_read,
        output rx_data,
        output data_ready,
        output overrun_error,
        output framing_error
    );

    modport slave (
        output serial_in,
        output data_read,
        input  rx_data,
        input  data_ready,
        input  overrun_error,
        input  framing_error
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : UART receiver; mid-bit sampling, LSB first, holding register
//               with ready, overrun and framing flags.
// Revision    : 1.0
// ============================================================================
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  wire logic      clk,
    input  wire logic      n_rst,
    uart_rx_core_if.master bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] C_HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] C_FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
    localparam logic [2:0] S_STOP     = 3'd3;
    localparam logic [2:0] S_ERR_WAIT = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_prev;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_data_ready;
    logic                 r_overrun;
    logic                 r_framing;

    logic w_start_edge;
    logic w_half;
    logic w_full;
    logic w_cnt_inc;
    logic w_shift_en;
    logic w_load;
    logic w_frame_err;
    logic w_fe_clr;

    assign w_start_edge = r_prev & ~r_sync2;
    assign w_half       = (r_cnt == C_HALF_M1);
    assign w_full       = (r_cnt == C_FULL_M1);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= bus.serial_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (w_start_edge) w_next_state = S_START;
            S_START:    if (w_half) w_next_state = r_sync2 ? S_IDLE : S_DATA;
            S_DATA:     if (w_full && (r_idx == C_LAST_IDX)) w_next_state = S_STOP;
            S_STOP:     if (w_full) w_next_state = r_sync2 ? S_IDLE : S_ERR_WAIT;
            S_ERR_WAIT: if (r_sync2) w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_inc   = 1'b0;
        w_shift_en  = 1'b0;
        w_load      = 1'b0;
        w_frame_err = 1'b0;
        w_fe_clr    = 1'b0;
        case (r_state)
            S_IDLE:  w_fe_clr = w_start_edge;
            S_START: w_cnt_inc = ~w_half;
            S_DATA: begin
                w_cnt_inc  = ~w_full;
                w_shift_en = w_full;
            end
            S_STOP: begin
                w_cnt_inc   = ~w_full;
                w_load      = w_full & r_sync2;
                w_frame_err = w_full & ~r_sync2;
            end
            default: ;
        endcase
    end

    // Counter restarts at every sample point so each phase measures from zero
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_cnt <= w_cnt_inc ? r_cnt + 1'b1 : '0;
            if (w_shift_en) begin
                r_shift[r_idx] <= r_sync2;
                r_idx          <= (r_idx == C_LAST_IDX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // A load coinciding with data_read wins, and that read suppresses overrun
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_rx_data    <= '1;
            r_data_ready <= 1'b0;
            r_overrun    <= 1'b0;
            r_framing    <= 1'b0;
        end else begin
            if (w_load) begin
                r_rx_data    <= r_shift;
                r_data_ready <= 1'b1;
                if (bus.data_read) begin
                    r_overrun <= 1'b0;
                end else if (r_data_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (bus.data_read) begin
                r_data_ready <= 1'b0;
                r_overrun    <= 1'b0;
            end

            if (w_frame_err) begin
                r_framing <= 1'b1;
            end else if (w_fe_clr) begin
                r_framing <= 1'b0;
            end
        end
    end

    assign bus.rx_data       = r_rx_data;
    assign bus.data_ready    = r_data_ready;
    assign bus.overrun_error = r_overrun;
    assign bus.framing_error = r_framing;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_core
// Description : Frame-timing reference model with per-cycle output compare,
//               directed scenarios and randomized frames.
// Revision    : 1.0
// ============================================================================
module tb_uart_rx_core;
    localparam int C = 10;
    localparam int D = 8;
    localparam int H = C / 2;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    uart_rx_core_if #(.DATA_BITS(D)) bus ();

    uart_rx_core #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   f_start  = 0;
    int   rise_cyc = -1;
    int   latency  = 0;
    logic rnd_read = 1'b0;
    logic cmp_en   = 1'b0;
    logic last_rdy = 1'b0;

    // Reference model: synchronised line plus frame timing relative to the start edge E
    logic         m_s1 = 1'b1, m_s2 = 1'b1, m_prev = 1'b1;
    int           mode = 0;
    int           e_cyc = 0;
    int           off, k;
    logic         old_ready, rd;
    logic [D-1:0] m_shift  = '0;
    logic [D-1:0] exp_data = '1;
    logic         exp_ready = 1'b0, exp_ovr = 1'b0, exp_fe = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (!n_rst) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_prev = 1'b1;
            mode = 0; m_shift = '0;
            exp_data = '1; exp_ready = 1'b0; exp_ovr = 1'b0; exp_fe = 1'b0;
        end else begin
            rd        = bus.data_read;
            old_ready = exp_ready;
            if (rd) begin
                exp_ready = 1'b0;
                exp_ovr   = 1'b0;
            end
            case (mode)
                0: if (m_prev && !m_s2) begin
                    mode = 1; e_cyc = cyc; exp_fe = 1'b0;
                end
                1: begin
                    off = cyc - e_cyc;
                    if (off == H) begin
                        if (m_s2) mode = 0;
                    end else if (off > H && (off - H) % C == 0) begin
                        k = (off - H) / C;
                        if (k <= D) begin
                            m_shift = {m_s2, m_shift[D-1:1]};
                        end else if (m_s2) begin
                            exp_data  = m_shift;
                            exp_ready = 1'b1;
                            if (old_ready && !rd) exp_ovr = 1'b1;
                            mode = 0;
                        end else begin
                            exp_fe = 1'b1;
                            mode   = 2;
                        end
                    end
                end
                default: if (m_s2) mode = 0;
            endcase
            m_prev = m_s2; m_s2 = m_s1; m_s1 = bus.serial_in;
        end
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("rx_data",       32'(bus.rx_data),       32'(exp_data));
            check("data_ready",    32'(bus.data_ready),    32'(exp_ready));
            check("overrun_error", 32'(bus.overrun_error), 32'(exp_ovr));
            check("framing_error", 32'(bus.framing_error), 32'(exp_fe));
        end
        if (bus.data_ready === 1'b1 && !last_rdy) rise_cyc = cyc;
        last_rdy = (bus.data_ready === 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.data_read = rnd_read && ($urandom_range(0, 15) == 0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic check_out(input string tag, input logic [D-1:0] d,
                             input logic rdy, input logic ovr, input logic fe);
        check({tag, ".rx_data"}, 32'(bus.rx_data),       32'(d));
        check({tag, ".ready"},   32'(bus.data_ready),    32'(rdy));
        check({tag, ".overrun"}, 32'(bus.overrun_error), 32'(ovr));
        check({tag, ".framing"}, 32'(bus.framing_error), 32'(fe));
    endtask

    // One frame, no gap; read_at / rst_at are cycle offsets from the start bit (-1 = none)
    task automatic send_frame(input logic [D-1:0] d, input logic stop,
                              input int read_at, input int rst_at);
        logic [D-1:0] tmp;
        int           b;
        f_start = cyc;
        for (int n = 0; n < (D + 2) * C; n++) begin
            b = n / C;
            if (b == 0) begin
                bus.serial_in = 1'b0;
            end else if (b <= D) begin
                tmp = d >> (b - 1);
                bus.serial_in = tmp[0];
            end else begin
                bus.serial_in = stop;
            end
            if (n == read_at) bus.data_read = 1'b1;
            if (n == rst_at) begin
                n_rst = 1'b0;
                bus.serial_in = 1'b1;
                step();
                n_rst = 1'b1;
                return;
            end
            step();
        end
    endtask

    initial begin
        logic         stop_b;
        logic [D-1:0] rnd_d;
        bus.serial_in = 1'b1;
        bus.data_read = 1'b0;
        n_rst = 1'b0;
        step();
        cmp_en = 1'b1;
        step();
        check_out("reset", 8'hFF, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        wait_cycles(5);

        send_frame(8'hA5, 1'b1, -1, -1);
        latency = rise_cyc - f_start;
        wait_cycles(5);
        check("latency", 32'(latency), 32'd98);
        check_out("single", 8'hA5, 1'b1, 1'b0, 1'b0);

        send_frame(8'h3C, 1'b1, -1, -1);
        send_frame(8'hC3, 1'b1, -1, -1);
        wait_cycles(5);
        check_out("overrun", 8'hC3, 1'b1, 1'b1, 1'b0);
        bus.data_read = 1'b1;
        step();
        check_out("read", 8'hC3, 1'b0, 1'b0, 1'b0);

        send_frame(8'h55, 1'b0, -1, -1);
        wait_cycles(20 * C);
        check_out("break", 8'hC3, 1'b0, 1'b0, 1'b1);
        bus.serial_in = 1'b1;
        wait_cycles(10);
        check_out("released", 8'hC3, 1'b0, 1'b0, 1'b1);
        send_frame(8'h0F, 1'b1, -1, -1);
        wait_cycles(5);
        check_out("after_fe", 8'h0F, 1'b1, 1'b0, 1'b0);

        bus.serial_in = 1'b0;
        wait_cycles(3);
        bus.serial_in = 1'b1;
        wait_cycles(3 * C);
        check_out("glitch", 8'h0F, 1'b1, 1'b0, 1'b0);

        send_frame(8'h81, 1'b1, 97, -1);
        wait_cycles(3);
        check_out("collision", 8'h81, 1'b1, 1'b0, 1'b0);

        send_frame(8'h5A, 1'b1, -1, 5 * C + 5);
        check_out("mid_reset", 8'hFF, 1'b0, 1'b0, 1'b0);
        wait_cycles(2 * C);
        send_frame(8'h12, 1'b1, -1, -1);
        wait_cycles(5);
        check_out("post_reset", 8'h12, 1'b1, 1'b0, 1'b0);

        rnd_read = 1'b1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 5) == 0) begin
                bus.serial_in = 1'b0;
                wait_cycles($urandom_range(1, 3));
                bus.serial_in = 1'b1;
                wait_cycles(C);
            end
            rnd_d  = D'($urandom);
            stop_b = ($urandom_range(0, 7) != 0);
            send_frame(rnd_d, stop_b, -1, -1);
            if (!stop_b) begin
                wait_cycles($urandom_range(0, 2 * C));
                bus.serial_in = 1'b1;
            end
            wait_cycles($urandom_range(0, 3 * C));
        end
        rnd_read = 1'b0;
        wait_cycles(2 * C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
